prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 29 ++
 rtl/word_packer.sv | 75 +++++++
 rtl/prog_loader.sv | 135 +++++++++++++
 tb/tb_prog_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader.
// State encoding, parameter defaults and width helpers.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int WORD_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;
  localparam int HOLD_DEF   = 10;
  localparam int RUN_DEF    = 100;

  function automatic int addr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  // Phase counter only ever reaches max(hold, run) - 1.
  function automatic int cnt_w(input int h, input int r);
    int m;
    m = (h > r) ? h : r;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream MSB-first into words; a short final word is zero-filled.
// Ports: clk, rst, clr_i, byte_valid_i, byte_i, last_i -> word_valid_o, word_last_o, word_o.
module word_packer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  input  logic              last_i,
  output logic              word_valid_o,
  output logic              word_last_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int NB    = WORD_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              vld_q, vld_d;
  logic              lst_q, lst_d;
  logic [WORD_W-1:0] merged;
  logic              full;

  always_comb begin
    merged = buf_q
           | (WORD_W'(byte_i) << (WORD_W - 8 - 8 * int'(idx_q)));
    full   = (idx_q == IDX_W'(NB - 1));
    idx_d  = idx_q;
    buf_d  = buf_q;
    word_d = word_q;
    vld_d  = 1'b0;
    lst_d  = 1'b0;
    if (clr_i) begin
      idx_d = '0;
      buf_d = '0;
    end else if (byte_valid_i) begin
      if (full || last_i) begin
        // buf restarts at zero, which also zero-fills short words
        idx_d  = '0;
        buf_d  = '0;
        word_d = merged;
        vld_d  = 1'b1;
        lst_d  = last_i;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        buf_d = merged;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      buf_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
      lst_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      buf_q  <= buf_d;
      word_q <= word_d;
      vld_q  <= vld_d;
      lst_q  <= lst_d;
    end
  end

  assign word_valid_o = vld_q;
  assign word_last_o  = lst_q;
  assign word_o       = word_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a program into memory, holds the CPU, runs it until halt or timeout.
// Ports: byte stream in, memory write out, cpu_run/halt, done/timeout/overflow status.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF,
  parameter int RUN_CYCLES  = RUN_DEF,
  localparam int ADDR_W     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_run,
  input  logic              halt,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W   = cnt_w(HOLD_CYCLES, RUN_CYCLES);
  localparam int HOLD_LS = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int RUN_LS  = (RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              to_q, to_d;
  logic              ov_q, ov_d;
  logic              clr;
  logic              room;
  logic              wv, wl;
  logic [WORD_W-1:0] wdata;

  word_packer #(
    .WORD_W(WORD_W)
  ) u_pack (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .byte_valid_i(in_valid && in_ready),
    .byte_i      (in_data),
    .last_i      (in_last),
    .word_valid_o(wv),
    .word_last_o (wl),
    .word_o      (wdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    to_d    = to_q;
    ov_d    = ov_q;
    clr     = 1'b0;
    room    = (words_q < (ADDR_W+1)'(DEPTH));
    // no new bytes while the final word is being written
    in_ready = (state_q == S_LOAD) && !(wv && wl);
    mem_we   = wv && room;
    if (mem_we) words_d = words_q + 1'b1;
    if (wv && !room) ov_d = 1'b1;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          words_d = '0;
          to_d    = 1'b0;
          ov_d    = 1'b0;
          clr     = 1'b1;
        end
      end
      S_LOAD: begin
        if (wv && wl) begin
          cnt_d   = '0;
          state_d = (HOLD_CYCLES == 0) ? S_RUN : S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_LS)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_DONE;
          to_d    = 1'b0;
        end else if (cnt_q == CNT_W'(RUN_LS)) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      words_q <= '0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      to_q    <= to_d;
      ov_q    <= ov_d;
    end
  end

  assign mem_addr     = words_q[ADDR_W-1:0];
  assign mem_wdata    = wdata;
  assign cpu_run      = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign timeout      = to_q;
  assign overflow     = ov_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader (WORD_W=32, DEPTH=4, HOLD=10, RUN=100).
// Table vectors, randomized sessions against a queue model, reset corner cases.
module tb_prog_loader;

  localparam int HOLD = 10;
  localparam int RUNC = 100;
  localparam int DEP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        halt;
  logic        done;
  logic        timeout;
  logic        overflow;
  logic [2:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sess_bytes[$];
  int          got_a[$];
  logic [31:0] got_d[$];
  logic [31:0] exp_d[$];

  always #5 clk = ~clk;

  prog_loader #(
    .WORD_W(32),
    .DEPTH(DEP),
    .HOLD_CYCLES(HOLD),
    .RUN_CYCLES(RUNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_run(cpu_run),
    .halt(halt),
    .done(done),
    .timeout(timeout),
    .overflow(overflow),
    .words_loaded(words_loaded)
  );

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      got_a.push_back(int'(mem_addr));
      got_d.push_back(mem_wdata);
    end
  end

  typedef struct {
    int          nb;
    logic [7:0]  base;
    logic [7:0]  step;
    int          halt_at;
    int          exp_nw;
    logic [31:0] exp_w0;
    logic [31:0] exp_wl;
    bit          exp_ov;
    bit          exp_to;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic session(input int halt_at, output int hold_n,
                         output int run_n);
    int idx;
    int g;
    bit v;
    bit x;
    got_a.delete();
    got_d.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_words", 64'(words_loaded), 64'd0);
    chk("clr_status", 64'({done, timeout, overflow}), 64'd0);
    chk("rdy_load", 64'(in_ready), 64'd1);
    idx = 0;
    g = 0;
    while (idx < sess_bytes.size() && g < 2000) begin
      v = ($urandom_range(0, 3) != 0);
      in_valid = v;
      in_data = sess_bytes[idx];
      in_last = (idx == sess_bytes.size() - 1);
      x = v && in_ready;
      @(negedge clk);
      if (x) idx++;
      g++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("stream", 64'(idx), 64'(sess_bytes.size()));
    chk("rdy_after_last", 64'(in_ready), 64'd0);
    hold_n = 0;
    run_n = 0;
    g = 0;
    @(negedge clk);
    while (!cpu_run && g < 1000) begin
      hold_n++;
      g++;
      @(negedge clk);
    end
    while (cpu_run && g < 2000) begin
      run_n++;
      g++;
      if (run_n == halt_at) halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
    end
    chk("done", 64'(done), 64'd1);
    chk("rdy_done", 64'(in_ready), 64'd0);
    chk("run_done", 64'(cpu_run), 64'd0);
  endtask

  task automatic fill_vec(input int t);
    sess_bytes.delete();
    for (int i = 0; i < tbl[t].nb; i++)
      sess_bytes.push_back(tbl[t].base + tbl[t].step * 8'(i));
  endtask

  task automatic run_vec(input int t);
    int hn;
    int rn;
    int er;
    fill_vec(t);
    session(tbl[t].halt_at, hn, rn);
    er = (tbl[t].halt_at != 0) ? tbl[t].halt_at : RUNC;
    chk($sformatf("v%0d_nw", t), 64'(got_a.size()), 64'(tbl[t].exp_nw));
    for (int j = 0; j < got_a.size(); j++)
      chk($sformatf("v%0d_addr%0d", t, j), 64'(got_a[j]), 64'(j));
    if (got_d.size() > 0) begin
      chk($sformatf("v%0d_w0", t), 64'(got_d[0]), 64'(tbl[t].exp_w0));
      chk($sformatf("v%0d_wl", t), 64'(got_d[got_d.size()-1]),
          64'(tbl[t].exp_wl));
    end
    chk($sformatf("v%0d_wcnt", t), 64'(words_loaded), 64'(tbl[t].exp_nw));
    chk($sformatf("v%0d_ov", t), 64'(overflow), 64'(tbl[t].exp_ov));
    chk($sformatf("v%0d_to", t), 64'(timeout), 64'(tbl[t].exp_to));
    chk($sformatf("v%0d_hold", t), 64'(hn), 64'(HOLD));
    chk($sformatf("v%0d_run", t), 64'(rn), 64'(er));
  endtask

  task automatic run_rand(input int r);
    int n;
    int nw;
    int ha;
    int sel;
    int hn;
    int rn;
    logic [31:0] w;
    n = $urandom_range(1, 22);
    sess_bytes.delete();
    for (int i = 0; i < n; i++) sess_bytes.push_back(8'($urandom));
    sel = $urandom_range(0, 3);
    ha = (sel == 0) ? 0 : (sel == 1) ? RUNC : $urandom_range(1, RUNC - 1);
    nw = (n + 3) / 4;
    exp_d.delete();
    for (int wi = 0; wi < nw && wi < DEP; wi++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++)
        if (4 * wi + k < n)
          w = w + (32'(sess_bytes[4*wi+k]) << (24 - 8 * k));
      exp_d.push_back(w);
    end
    session(ha, hn, rn);
    chk($sformatf("r%0d_nw", r), 64'(got_d.size()), 64'(exp_d.size()));
    for (int j = 0; j < exp_d.size() && j < got_d.size(); j++) begin
      chk($sformatf("r%0d_a%0d", r, j), 64'(got_a[j]), 64'(j));
      chk($sformatf("r%0d_d%0d", r, j), 64'(got_d[j]), 64'(exp_d[j]));
    end
    chk($sformatf("r%0d_ov", r), 64'(overflow), 64'(nw > DEP));
    chk($sformatf("r%0d_to", r), 64'(timeout), 64'(ha == 0));
    chk($sformatf("r%0d_hold", r), 64'(hn), 64'(HOLD));
    chk($sformatf("r%0d_run", r), 64'(rn), 64'((ha != 0) ? ha : RUNC));
  endtask

  function automatic logic [63:0] all_out();
    return 64'({in_ready, mem_we, cpu_run, done, timeout, overflow,
                words_loaded, mem_addr, mem_wdata});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8, 8'h01, 8'h01, 0, 2, 32'h01020304, 32'h05060708, 1'b0, 1'b1};
    tbl[1] = '{3, 8'hAA, 8'h11, 37, 1, 32'hAABBCC00, 32'hAABBCC00, 1'b0, 1'b0};
    tbl[2] = '{20, 8'h10, 8'h01, 100, 4, 32'h10111213, 32'h1C1D1E1F, 1'b1, 1'b0};
    tbl[3] = '{16, 8'h30, 8'h02, 1, 4, 32'h30323436, 32'h484A4C4E, 1'b0, 1'b0};
    tbl[4] = '{1, 8'h5A, 8'h00, 0, 1, 32'h5A000000, 32'h5A000000, 1'b0, 1'b1};
    tbl[5] = '{6, 8'hF0, 8'h01, 50, 2, 32'hF0F1F2F3, 32'hF4F50000, 1'b0, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", all_out(), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", all_out(), 64'd0);

    for (int t = 0; t < 6; t++) run_vec(t);
    for (int r = 0; r < 8; r++) run_rand(r);

    // reset in the write cycle of the first word, with bytes pending
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_rst_we", 64'(mem_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", all_out(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_stay_idle", all_out(), 64'd0);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
